// File: rtl/instr_fetch_pkg.sv
// Shared ISA definitions: core count and opcode values used by the fetch/decode logic and the memory image.
package instr_fetch_pkg;

  localparam int unsigned NUM_C = 4;

  localparam int unsigned OP_NOP   = 0;
  localparam int unsigned OP_LDAC  = 6;
  localparam int unsigned OP_STAC  = 8;
  localparam int unsigned OP_CLAC  = 27;
  localparam int unsigned OP_JPNZ  = 29;
  localparam int unsigned OP_JPPZ  = 31;
  localparam int unsigned OP_ENDOP = 43;

endpackage

// File: rtl/instr_fetch_opcode_len.sv
// Combinational opcode length decode: flags opcodes that carry a second (operand) word.
module opcode_len
  import instr_fetch_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] op_i,
  output logic              has_operand_o
);

  always_comb begin
    has_operand_o = 1'b0;
    if (op_i == DATA_W'(OP_LDAC) || op_i == DATA_W'(OP_STAC) ||
        op_i == DATA_W'(OP_JPNZ) || op_i == DATA_W'(OP_JPPZ)) begin
      has_operand_o = 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Per-core fetch sequencer: PC, 1-cycle memory latency, 1/2-word assembly, valid/ready issue, jumps.
// IFETCH_ENDOP_HALT_EN: when defined, an accepted ENDOP parks the block in S_HALT until rst.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [DATA_W-1:0] im_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_op,
  output logic [DATA_W-1:0] instr_operand,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              halted
);

  typedef enum logic [2:0] {S_FETCH, S_OPD, S_ARGD, S_ISSUE, S_HALT} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q, ipc_q, pc_step_d;
  logic [DATA_W-1:0] op_q, arg_q;
  logic              vld_q, opd_q, mem_has_opd;
`ifdef IFETCH_ENDOP_HALT_EN
  logic              halted_q;
`endif

  opcode_len #(.DATA_W(DATA_W)) u_len (
    .op_i          (im_data),
    .has_operand_o (mem_has_opd)
  );

  assign pc_step_d = pc_q + (opd_q ? ADDR_W'(2) : ADDR_W'(1));

  always_comb begin
    im_addr = pc_q;
    if (state_q == S_OPD) im_addr = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ipc_q   <= RESET_PC;
      op_q    <= '0;
      arg_q   <= '0;
      opd_q   <= 1'b0;
      vld_q   <= 1'b0;
`ifdef IFETCH_ENDOP_HALT_EN
      halted_q <= 1'b0;
`endif
    end else if (jump_req && state_q != S_HALT) begin
      // A handshake in this cycle still completes; the target simply replaces the stepped PC.
      pc_q    <= jump_target;
      vld_q   <= 1'b0;
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_OPD;
        S_OPD: begin
          op_q  <= im_data;
          ipc_q <= pc_q;
          opd_q <= mem_has_opd;
          if (mem_has_opd) begin
            state_q <= S_ARGD;
          end else begin
            arg_q   <= '0;
            vld_q   <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ARGD: begin
          arg_q   <= im_data;
          vld_q   <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (instr_ready) begin
            vld_q <= 1'b0;
            pc_q  <= pc_step_d;
`ifdef IFETCH_ENDOP_HALT_EN
            if (op_q == DATA_W'(OP_ENDOP)) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= S_FETCH;
            end
`else
            state_q <= S_FETCH;
`endif
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign instr_valid   = vld_q;
  assign instr_op      = op_q;
  assign instr_operand = arg_q;
  assign instr_pc      = ipc_q;
`ifdef IFETCH_ENDOP_HALT_EN
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

endmodule
